// File: rtl/hdmi_video_out.sv
// hdmi_video_out: 2-stage retiming output stage for the ADV7513 parallel RGB bus with raster measurement and lock detect.
// Optional per-frame CRC-16-CCITT of active pixels is built when HDMI_OUT_FRAME_CRC_EN is defined.
module hdmi_video_out #(
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_vga_hs,
  input  logic        i_vga_vs,
  input  logic        i_vga_de,
  input  logic [7:0]  i_vga_r,
  input  logic [7:0]  i_vga_g,
  input  logic [7:0]  i_vga_b,
  input  logic [11:0] i_exp_h_active,
  input  logic [11:0] i_exp_v_active,
  output logic        o_hdmi_hs,
  output logic        o_hdmi_vs,
  output logic        o_hdmi_de,
  output logic [23:0] o_hdmi_d,
  output logic [11:0] o_meas_h_total,
  output logic [11:0] o_meas_h_active,
  output logic [11:0] o_meas_v_total,
  output logic [11:0] o_meas_v_active,
  output logic        o_timing_locked,
  output logic        o_timing_err,
  output logic [15:0] o_frame_crc,
  output logic        o_frame_crc_valid
);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic        r_s1_hs, r_s1_vs, r_s1_de;
  logic [23:0] r_s1_rgb;
  logic        r_hs_prev, r_vs_prev;
  logic [11:0] r_pix_cnt, r_de_cnt, r_line_cnt, r_act_lines;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_match_cnt, w_match_cnt_nxt;
  logic        w_locked_nxt, w_err_nxt;
  logic        w_line_close, w_frame_close, w_has_de, w_match;
  logic [11:0] w_line_cnt_upd, w_act_upd, w_h_act_upd;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Stage 1 captures the generator; prev copies of hs/vs idle high so reset never fakes an edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_s1_de   <= 1'b0;
      r_s1_rgb  <= '0;
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_s1_hs   <= i_vga_hs;
      r_s1_vs   <= i_vga_vs;
      r_s1_de   <= i_vga_de;
      r_s1_rgb  <= {i_vga_r, i_vga_g, i_vga_b};
      r_hs_prev <= r_s1_hs;
      r_vs_prev <= r_s1_vs;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hdmi_hs <= ~HS_POL;
      o_hdmi_vs <= ~VS_POL;
      o_hdmi_de <= 1'b0;
      o_hdmi_d  <= '0;
    end else begin
      o_hdmi_hs <= r_s1_hs ? ~HS_POL : HS_POL;
      o_hdmi_vs <= r_s1_vs ? ~VS_POL : VS_POL;
      o_hdmi_de <= r_s1_de;
      o_hdmi_d  <= r_s1_de ? r_s1_rgb : 24'h0;
    end
  end

  assign w_line_close  = r_hs_prev & ~r_s1_hs;
  assign w_frame_close = r_vs_prev & ~r_s1_vs;
  assign w_has_de      = w_line_close && (r_de_cnt != 12'd0);

  // Line close is folded in first so a coincident frame close sees the finished line.
  assign w_line_cnt_upd = w_line_close ? sat_inc(r_line_cnt) : r_line_cnt;
  assign w_act_upd      = w_has_de ? sat_inc(r_act_lines) : r_act_lines;
  assign w_h_act_upd    = w_has_de ? r_de_cnt : o_meas_h_active;
  assign w_match        = (w_h_act_upd == i_exp_h_active) && (w_act_upd == i_exp_v_active);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pix_cnt       <= '0;
      r_de_cnt        <= '0;
      r_line_cnt      <= '0;
      r_act_lines     <= '0;
      o_meas_h_total  <= '0;
      o_meas_h_active <= '0;
      o_meas_v_total  <= '0;
      o_meas_v_active <= '0;
    end else begin
      if (w_line_close) begin
        o_meas_h_total <= r_pix_cnt;
        r_pix_cnt      <= 12'd1;
        r_de_cnt       <= '0;
      end else begin
        r_pix_cnt <= sat_inc(r_pix_cnt);
        if (r_s1_de) r_de_cnt <= sat_inc(r_de_cnt);
      end
      o_meas_h_active <= w_h_act_upd;
      if (w_frame_close) begin
        o_meas_v_total  <= w_line_cnt_upd;
        o_meas_v_active <= w_act_upd;
        r_line_cnt      <= '0;
        r_act_lines     <= '0;
      end else begin
        r_line_cnt  <= w_line_cnt_upd;
        r_act_lines <= w_act_upd;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= ST_SEARCH;
      r_match_cnt     <= '0;
      o_timing_locked <= 1'b0;
      o_timing_err    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_match_cnt     <= w_match_cnt_nxt;
      o_timing_locked <= w_locked_nxt;
      o_timing_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_match_cnt_nxt = r_match_cnt;
    w_locked_nxt    = o_timing_locked;
    w_err_nxt       = 1'b0;
    if (w_frame_close) begin
      case (r_state)
        ST_SEARCH: begin
          w_state_nxt     = ST_MEASURE;
          w_match_cnt_nxt = '0;
        end
        ST_MEASURE: begin
          if (w_match) begin
            w_match_cnt_nxt = r_match_cnt + 4'd1;
            if ((r_match_cnt + 4'd1) >= LOCK_N) begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_match_cnt_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_match) begin
            w_state_nxt     = ST_MEASURE;
            w_match_cnt_nxt = '0;
            w_locked_nxt    = 1'b0;
            w_err_nxt       = 1'b1;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

`ifdef HDMI_OUT_FRAME_CRC_EN
  logic [15:0] r_crc_acc;
  logic        r_crc_armed;

  // 24 bits per pixel, MSB first, poly 0x1021.
  function automatic logic [15:0] crc16_px(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] v;
    logic        fb;
    v = c;
    for (int i = 23; i >= 0; i--) begin
      fb = v[15] ^ d[i];
      v  = {v[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return v;
  endfunction

  // The first frame close only arms publication; its partial frame is dropped.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_crc_acc         <= 16'hFFFF;
      r_crc_armed       <= 1'b0;
      o_frame_crc       <= '0;
      o_frame_crc_valid <= 1'b0;
    end else begin
      o_frame_crc_valid <= 1'b0;
      if (w_frame_close) begin
        r_crc_acc   <= 16'hFFFF;
        r_crc_armed <= 1'b1;
        if (r_crc_armed) begin
          o_frame_crc       <= r_crc_acc;
          o_frame_crc_valid <= 1'b1;
        end
      end else if (r_s1_de) begin
        r_crc_acc <= crc16_px(r_crc_acc, r_s1_rgb);
      end
    end
  end
`else
  assign o_frame_crc       = '0;
  assign o_frame_crc_valid = 1'b0;
`endif

endmodule
